hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_pkg.sv | 19 +
 rtl/hazard_scoreboard_if.sv | 30 +++
 rtl/md_busy_counter.sv | 24 ++
 rtl/hazard_scoreboard.sv | 81 ++++++++
 tb/tb_hazard_scoreboard.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared defaults, unused-source marker and forward-source encoding for the hazard scoreboard
package hazard_pkg;
    localparam int DEPTH_DEF    = 3;
    localparam int TW_DEF       = 2;
    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 10;
    localparam logic [TW_DEF-1:0] TUSE_NONE = '1;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_E  = 2'd1,
        FWD_M  = 2'd2,
        FWD_W  = 2'd3
    } fwd_sel_e;

    function automatic int cnt_width(input int a, input int b);
        return $clog2((a > b ? a : b) + 1);
    endfunction
endpackage

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: decode-stage request bundle and hazard/forward responses
interface hazard_scoreboard_if #(
    parameter int DEPTH = hazard_pkg::DEPTH_DEF,
    parameter int TW    = hazard_pkg::TW_DEF
);
    localparam int FW = $clog2(DEPTH + 1);
    logic          d_valid;
    logic [4:0]    d_rs;
    logic [4:0]    d_rt;
    logic [TW-1:0] d_tuse_rs;
    logic [TW-1:0] d_tuse_rt;
    logic [4:0]    d_waddr;
    logic [TW-1:0] d_tnew;
    logic          d_md_start;
    logic          d_md_div;
    logic          d_uses_hilo;
    logic          stall;
    logic [FW-1:0] fwd_rs;
    logic [FW-1:0] fwd_rt;
    logic          md_busy;

    modport master (
        output d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_waddr, d_tnew, d_md_start, d_md_div, d_uses_hilo,
        input  stall, fwd_rs, fwd_rt, md_busy
    );
    modport slave (
        input  d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_waddr, d_tnew, d_md_start, d_md_div, d_uses_hilo,
        output stall, fwd_rs, fwd_rt, md_busy
    );
endinterface

// File: rtl/md_busy_counter.sv
// md_busy_counter: HI/LO busy countdown, reloaded on every accepted mult/div issue
module md_busy_counter
    import hazard_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load_i,
    input  logic div_i,
    output logic busy_o
);
    localparam int CW = cnt_width(MULT_LAT, DIV_LAT);
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb cnt_d = load_i ? (div_i ? CW'(DIV_LAT) : CW'(MULT_LAT)) : cnt_q - CW'(cnt_q != '0);

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;

    assign busy_o = cnt_q != '0;
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight writers after D and derives stall and forward selects
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int DEPTH    = DEPTH_DEF,
    parameter int TW       = TW_DEF,
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF
) (
    input logic clk,
    input logic reset_n,
    hazard_scoreboard_if.slave bus
);
    localparam int FW = $clog2(DEPTH + 1);
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [4:0]       waddr_q [DEPTH];
    logic [4:0]       waddr_d [DEPTH];
    logic [TW-1:0]    tnew_q [DEPTH];
    logic [TW-1:0]    tnew_d [DEPTH];
    logic [4:0]       src [2];
    logic [TW-1:0]    tuse [2];
    logic [1:0]       dstall;
    logic [FW-1:0]    fwd [2];
    logic             md_busy, stall, accept;

    assign src[0]  = bus.d_rs;
    assign src[1]  = bus.d_rt;
    assign tuse[0] = bus.d_tuse_rs;
    assign tuse[1] = bus.d_tuse_rt;

    // Scan oldest to youngest so the lowest-index match has the final say
    always_comb begin
        dstall = '0;
        for (int s = 0; s < 2; s++) begin
            fwd[s] = '0;
            for (int k = DEPTH - 1; k >= 0; k--)
                if (valid_q[k] && waddr_q[k] != 5'd0 && waddr_q[k] == src[s]) begin
                    dstall[s] = (tuse[s] != '1) && (tuse[s] < tnew_q[k]);
                    fwd[s]    = (tnew_q[k] == '0) ? FW'(k + 1) : '0;
                end
        end
    end

    assign stall  = bus.d_valid & ((|dstall) | (bus.d_uses_hilo & md_busy));
    assign accept = bus.d_valid & ~stall;

    always_comb begin
        valid_d[0] = accept;
        waddr_d[0] = bus.d_waddr;
        tnew_d[0]  = bus.d_tnew;
        for (int k = 1; k < DEPTH; k++) begin
            valid_d[k] = valid_q[k-1];
            waddr_d[k] = waddr_q[k-1];
            tnew_d[k]  = tnew_q[k-1] - TW'(tnew_q[k-1] != '0);
        end
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            valid_q <= '0;
            waddr_q <= '{default: '0};
            tnew_q  <= '{default: '0};
        end else begin
            valid_q <= valid_d;
            waddr_q <= waddr_d;
            tnew_q  <= tnew_d;
        end

    md_busy_counter #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) u_md (
        .clk    (clk),
        .reset_n(reset_n),
        .load_i (accept & bus.d_md_start),
        .div_i  (bus.d_md_div),
        .busy_o (md_busy)
    );

    assign bus.stall   = stall;
    assign bus.fwd_rs  = fwd[0];
    assign bus.fwd_rt  = fwd[1];
    assign bus.md_busy = md_busy;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed and random checks against a per-cycle history model
module tb_hazard_scoreboard;
    import hazard_pkg::*;
    localparam int DEPTH = DEPTH_DEF;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int n_chk = 0, n_fail = 0, t = 0, rst_cyc = 0, md_issue = -1000, md_lat = 0;
    logic acc_v [4096];
    logic [4:0] acc_w [4096];
    int acc_tn [4096];
    logic obs_stall, obs_busy;
    logic [1:0] obs_fwd_rs;
    int cnt;

    hazard_scoreboard_if bus();
    hazard_scoreboard dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic [1:0] tur, input logic [4:0] rt,
                         input logic [1:0] tut, input logic [4:0] wa, input logic [1:0] tn,
                         input logic ms, input logic md, input logic uh);
        bus.d_valid = v; bus.d_rs = rs; bus.d_tuse_rs = tur; bus.d_rt = rt; bus.d_tuse_rt = tut;
        bus.d_waddr = wa; bus.d_tnew = tn; bus.d_md_start = ms; bus.d_md_div = md; bus.d_uses_hilo = uh;
    endtask

    // The instruction k stages past D at cycle tt is the one accepted from D at cycle tt-k;
    // its remaining latency shrinks by one per stage advanced beyond E.
    function automatic void lookup(input int tt, input logic [4:0] src, input logic [1:0] tuse,
                                   output logic st, output int fw);
        st = 1'b0;
        fw = 0;
        for (int k = 1; k <= DEPTH; k++)
            if (tt - k > rst_cyc && acc_v[tt-k] && acc_w[tt-k] != 5'd0 && acc_w[tt-k] == src) begin
                int tn;
                tn = acc_tn[tt-k] - (k - 1);
                if (tn < 0) tn = 0;
                st = (tuse != TUSE_NONE) && (int'(tuse) < tn);
                fw = (tn == 0) ? k : 0;
                return;
            end
    endfunction

    task automatic cycle(input string tag);
        logic s_rs, s_rt, busy, st;
        int f_rs, f_rt;
        @(negedge clk);
        lookup(t, bus.d_rs, bus.d_tuse_rs, s_rs, f_rs);
        lookup(t, bus.d_rt, bus.d_tuse_rt, s_rt, f_rt);
        busy = md_issue > rst_cyc && t > md_issue && t <= md_issue + md_lat;
        st = bus.d_valid && (s_rs || s_rt || (bus.d_uses_hilo && busy));
        obs_stall = bus.stall; obs_busy = bus.md_busy; obs_fwd_rs = bus.fwd_rs;
        chk({tag, ".stall"}, 8'(bus.stall), 8'(st));
        chk({tag, ".fwd_rs"}, 8'(bus.fwd_rs), 8'(f_rs));
        chk({tag, ".fwd_rt"}, 8'(bus.fwd_rt), 8'(f_rt));
        chk({tag, ".md_busy"}, 8'(bus.md_busy), 8'(busy));
        acc_v[t] = st ? 1'b0 : bus.d_valid;
        acc_w[t] = bus.d_waddr;
        acc_tn[t] = int'(bus.d_tnew);
        if (acc_v[t] && bus.d_md_start) begin
            md_issue = t;
            md_lat = bus.d_md_div ? DIV_LAT_DEF : MULT_LAT_DEF;
        end
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        #1;
        chk({tag, ".rst_stall"}, 8'(bus.stall), 8'h0);
        chk({tag, ".rst_fwd_rs"}, 8'(bus.fwd_rs), 8'h0);
        chk({tag, ".rst_fwd_rt"}, 8'(bus.fwd_rt), 8'h0);
        chk({tag, ".rst_md_busy"}, 8'(bus.md_busy), 8'h0);
        rst_cyc = t;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        t++;
    endtask

    task automatic idle(input int n);
        drive(0, 0, 3, 0, 3, 0, 0, 0, 0, 0);
        repeat (n) cycle("idle");
    endtask

    initial begin
        drive(0, 0, 3, 0, 3, 0, 0, 0, 0, 0);
        do_reset("init");
        idle(2);
        // load-use: lw $8 then addu $10,$8,$9
        drive(1, 29, 1, 0, 3, 8, 2, 0, 0, 0); cycle("lw");
        drive(1, 8, 1, 9, 1, 10, 1, 0, 0, 0); cycle("lu1");
        chk("lu_first_stall", 8'(obs_stall), 8'h1);
        cycle("lu2");
        chk("lu_released", 8'(obs_stall), 8'h0);
        idle(3);
        // ALU chain: addu $9 then beq on $9
        drive(1, 1, 1, 2, 1, 9, 1, 0, 0, 0); cycle("addu");
        drive(1, 9, 0, 0, 3, 0, 0, 0, 0, 0); cycle("beq1");
        chk("alu_stall", 8'(obs_stall), 8'h1);
        cycle("beq2");
        chk("alu_fwd_m", 8'(obs_fwd_rs), 8'(FWD_M));
        idle(3);
        // writes to $0 never create hazards
        drive(1, 1, 1, 0, 3, 0, 2, 0, 0, 0); cycle("wr0");
        drive(1, 0, 0, 0, 3, 4, 1, 0, 0, 0); cycle("rd0");
        chk("zero_stall", 8'(obs_stall), 8'h0);
        chk("zero_fwd", 8'(obs_fwd_rs), 8'(FWD_RF));
        idle(3);
        // two writers of $5 in flight: E wins over M
        drive(1, 1, 1, 0, 3, 5, 0, 0, 0, 0); cycle("wr5a");
        drive(1, 2, 1, 0, 3, 5, 0, 0, 0, 0); cycle("wr5b");
        drive(1, 5, 0, 0, 3, 0, 0, 0, 0, 0); cycle("rd5");
        chk("youngest_fwd_e", 8'(obs_fwd_rs), 8'(FWD_E));
        idle(3);
        // div then mflo
        drive(1, 4, 1, 5, 1, 0, 0, 1, 1, 1); cycle("div");
        drive(1, 0, 3, 0, 3, 8, 1, 0, 0, 1);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cycle("mflo");
            if (!obs_stall) break;
            cnt++;
        end
        chk("div_stall_cycles", 8'(cnt), 8'(DIV_LAT_DEF));
        chk("div_busy_at_accept", 8'(obs_busy), 8'h0);
        idle(2);
        // mult then mfhi
        drive(1, 4, 1, 5, 1, 0, 0, 1, 0, 1); cycle("mult");
        drive(1, 0, 3, 0, 3, 8, 1, 0, 0, 1);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cycle("mfhi");
            if (!obs_stall) break;
            cnt++;
        end
        chk("mult_stall_cycles", 8'(cnt), 8'(MULT_LAT_DEF));
        idle(2);
        // reset three cycles after div issue, with mflo waiting in D
        drive(1, 4, 1, 5, 1, 0, 0, 1, 1, 1); cycle("div2");
        drive(1, 0, 3, 0, 3, 8, 1, 0, 0, 1);
        cycle("mflo_w1");
        cycle("mflo_w2");
        do_reset("middiv");
        cycle("mflo_after_rst");
        chk("post_rst_accept", 8'(obs_stall), 8'h0);
        idle(2);
        // random traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) do_reset("rnd");
            drive($urandom_range(0, 9) < 8, 5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                  5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)),
                  2'($urandom_range(0, 2)), $urandom_range(0, 19) == 0, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 4) == 0);
            cycle("rnd");
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
